pwm_seq: RTL

Autonomous step sequencer that programs one channel of the 4-channel PWM peripheral through its register write port. Software loads a table of (period, high-time, hold) steps and a control word over a CPU-side register slave port; the block then walks the table, issuing PWM register writes and holding each step for a programmed number of clock cycles. It sits between the CPU data bus and the PWM block's `we_i`/`addr_i`/`data_i` inputs.

---
 rtl/pwm_seq_pkg.sv | 44 ++++
 rtl/pwm_seq_if.sv | 23 ++
 rtl/pwm_seq_regs.sv | 145 ++++++++++++++
 rtl/pwm_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: CPU-side register map, PWM target register offsets and the
// sequencer state encoding shared by the pwm_seq block and its register file.
package pwm_seq_pkg;

  // CPU-side register select values (addr_i[23:16]).
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h01;
  localparam logic [7:0] REG_LEN    = 8'h02;
  localparam logic [7:0] REG_PERIOD = 8'h20;
  localparam logic [7:0] REG_HIGH   = 8'h40;
  localparam logic [7:0] REG_HOLD   = 8'h60;

  // CTRL word bit positions.
  localparam int CTRL_START = 0;
  localparam int CTRL_LOOP  = 1;
  localparam int CTRL_STOP  = 2;
  localparam int CTRL_CH_LO = 4;

  // PWM block register selects: per-channel period (A) and high time (B)
  // banks, plus the global enable register (C).
  localparam logic [7:0]  PWM_A_BASE  = 8'h00;
  localparam logic [7:0]  PWM_B_BASE  = 8'h10;
  localparam logic [7:0]  PWM_C_REG   = 8'h04;
  localparam logic [31:0] PWM_C_VALUE = 32'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_A,
    ST_WR_B,
    ST_WR_C,
    ST_HOLD
  } state_t;

  // Place a register select into the PWM bus address; all other bits zero.
  function automatic logic [31:0] pwm_addr(input logic [7:0] sel);
    return {8'h00, sel, 16'h0000};
  endfunction

  // Per-channel register select inside a bank.
  function automatic logic [7:0] chan_sel(input logic [7:0] base, input logic [1:0] ch);
    return base + {6'b000000, ch};
  endfunction

endpackage

// File: rtl/pwm_seq_if.sv
// pwm_seq_if: CPU-side register bus of the sequencer. The CPU (master)
// drives the write strobe, address and write data; the sequencer (slave)
// returns combinational read data for the selected register.
interface pwm_seq_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output we_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  we_i,
    input  addr_i,
    input  data_i,
    output data_o
  );
endinterface

// File: rtl/pwm_seq_regs.sv
// pwm_seq_regs: CTRL/LEN/step-table storage for the PWM sequencer, the
// start/stop command decode, step-count clamping, the done sticky flag and
// the combinational CPU read mux. The table is plain registers because it
// must clear on reset and be readable combinationally from two ports.
module pwm_seq_regs
  import pwm_seq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  pwm_seq_if.slave          bus,
  input  logic              busy,
  input  logic              done_set,
  input  logic [IDX_W-1:0]  idx,
  output logic              start_req,
  output logic              stop_req,
  output logic              loop,
  output logic [1:0]        ch,
  output logic [IDX_W:0]    len_eff,
  output logic              done_sticky,
  output logic [31:0]       period_rd,
  output logic [31:0]       high_rd,
  output logic [HOLD_W-1:0] hold_rd
);

  localparam int LEN_W = IDX_W + 1;

  logic [7:0]       sel;
  logic             ctrl_wr;
  logic             status_wr;
  logic             len_wr;
  logic [3:0]       ent;
  logic             ent_ok;
  logic [IDX_W-1:0] ent_idx;
  logic             unused_addr_bits;

  logic [31:0]       len_reg;
  logic              loop_reg;
  logic [1:0]        ch_reg;
  logic              done_sticky_reg;
  logic [31:0]       rdata_next;

  logic [31:0]       period_arr [DEPTH];
  logic [31:0]       high_arr   [DEPTH];
  logic [HOLD_W-1:0] hold_arr   [DEPTH];

  assign sel       = bus.addr_i[23:16];
  assign ctrl_wr   = bus.we_i && (sel == REG_CTRL);
  assign status_wr = bus.we_i && (sel == REG_STATUS);
  assign len_wr    = bus.we_i && (sel == REG_LEN);
  assign ent       = sel[3:0];
  assign ent_ok    = ({1'b0, ent} < 5'(DEPTH));
  assign ent_idx   = ent[IDX_W-1:0];

  // Only the register select byte of the address is decoded.
  assign unused_addr_bits = ^{bus.addr_i[31:24], bus.addr_i[15:0]};

  // Stop takes priority over start; start is only accepted while idle.
  assign stop_req  = ctrl_wr && bus.data_i[CTRL_STOP];
  assign start_req = ctrl_wr && bus.data_i[CTRL_START] && !bus.data_i[CTRL_STOP] && !busy;

  // One register set per table entry, each with its own write decode.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tbl
      logic [31:0]       period_reg;
      logic [31:0]       high_reg;
      logic [HOLD_W-1:0] hold_reg;

      // Capture CPU writes to this entry's PERIOD/HIGH/HOLD words.
      always_ff @(posedge clk) begin
        if (!rst) begin
          period_reg <= '0;
          high_reg   <= '0;
          hold_reg   <= '0;
        end else if (bus.we_i) begin
          if (sel == (REG_PERIOD + 8'(gi))) period_reg <= bus.data_i;
          if (sel == (REG_HIGH + 8'(gi)))   high_reg   <= bus.data_i;
          if (sel == (REG_HOLD + 8'(gi)))   hold_reg   <= HOLD_W'(bus.data_i);
        end
      end

      assign period_arr[gi] = period_reg;
      assign high_arr[gi]   = high_reg;
      assign hold_arr[gi]   = hold_reg;
    end
  endgenerate

  // LEN storage, run options latched on an accepted start, done sticky flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_reg         <= '0;
      loop_reg        <= 1'b0;
      ch_reg          <= 2'b00;
      done_sticky_reg <= 1'b0;
    end else begin
      if (len_wr) len_reg <= bus.data_i;
      if (start_req) begin
        loop_reg <= bus.data_i[CTRL_LOOP];
        ch_reg   <= bus.data_i[CTRL_CH_LO +: 2];
      end
      // A completion in the same cycle as a STATUS write keeps the flag set.
      if (done_set)       done_sticky_reg <= 1'b1;
      else if (status_wr) done_sticky_reg <= 1'b0;
    end
  end

  // Effective step count: zero runs one step, oversize runs the whole table.
  always_comb begin
    len_eff = len_reg[LEN_W-1:0];
    if (len_reg == 32'd0)             len_eff = LEN_W'(1);
    else if (len_reg > 32'(DEPTH))    len_eff = LEN_W'(DEPTH);
  end

  // CPU read mux; forced to zero while reset is held.
  always_comb begin
    rdata_next = '0;
    if (rst) begin
      if (sel == REG_STATUS) begin
        rdata_next = {20'h00000, 4'(idx), 6'b000000, done_sticky_reg, busy};
      end else if (sel == REG_LEN) begin
        rdata_next = len_reg;
      end else if (ent_ok) begin
        case (sel[7:4])
          4'h2:    rdata_next = period_arr[ent_idx];
          4'h4:    rdata_next = high_arr[ent_idx];
          4'h6:    rdata_next = 32'(hold_arr[ent_idx]);
          default: rdata_next = '0;
        endcase
      end
    end
  end

  assign bus.data_o  = rdata_next;
  assign loop        = loop_reg;
  assign ch          = ch_reg;
  assign done_sticky = done_sticky_reg;
  assign period_rd   = period_arr[idx];
  assign high_rd     = high_arr[idx];
  assign hold_rd     = hold_arr[idx];

endmodule

// File: rtl/pwm_seq.sv
// pwm_seq: autonomous step sequencer driving one channel of the 4-channel
// PWM peripheral. Walks a table of (period, high, hold) steps, writing the
// channel's period and high-time registers per step (plus the enable
// register once at the start of a run) and holding each step for a
// programmed number of cycles.
// Optional build macro PWM_SEQ_IRQ_EN adds irq_o, mirroring the done sticky.
module pwm_seq
  import pwm_seq_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  pwm_seq_if.slave    bus,
  output logic        pwm_we_o,
  output logic [31:0] pwm_addr_o,
  output logic [31:0] pwm_data_o,
  output logic        busy_o,
  output logic        done_o
`ifdef PWM_SEQ_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [HOLD_W-1:0] cnt_reg, cnt_next;
  logic              first_reg, first_next;
  logic              done_reg, done_next;

  logic              start_req;
  logic              stop_req;
  logic              loop;
  logic [1:0]        ch;
  logic [LEN_W-1:0]  len_eff;
  logic              done_sticky;
  logic [31:0]       period_rd;
  logic [31:0]       high_rd;
  logic [HOLD_W-1:0] hold_rd;

  logic [HOLD_W-1:0] hold_load;
  logic [LEN_W-1:0]  idx_inc;
  logic              last_step;
  logic              busy;
  logic              wr_we;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;

  assign busy      = (state_reg != ST_IDLE);
  assign hold_load = (hold_rd == '0) ? HOLD_W'(1) : hold_rd;
  assign idx_inc   = {1'b0, idx_reg} + LEN_W'(1);
  assign last_step = (idx_inc >= len_eff);

  pwm_seq_regs #(
    .DEPTH  (DEPTH),
    .HOLD_W (HOLD_W),
    .IDX_W  (IDX_W)
  ) u_regs (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .done_set    (done_next | done_reg),
    .idx         (idx_reg),
    .start_req   (start_req),
    .stop_req    (stop_req),
    .loop        (loop),
    .ch          (ch),
    .len_eff     (len_eff),
    .done_sticky (done_sticky),
    .period_rd   (period_rd),
    .high_rd     (high_rd),
    .hold_rd     (hold_rd)
  );

  // Sequencer state, step index, hold counter and done pulse registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      first_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      first_reg <= first_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic and the PWM write issued in each write state.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    first_next = first_reg;
    done_next  = 1'b0;
    wr_we      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;

    case (state_reg)
      ST_IDLE: begin
        if (start_req) begin
          state_next = ST_WR_A;
          idx_next   = '0;
          first_next = 1'b1;
        end
      end
      ST_WR_A: begin
        wr_we      = 1'b1;
        wr_addr    = pwm_addr(chan_sel(PWM_A_BASE, ch));
        wr_data    = period_rd;
        state_next = ST_WR_B;
      end
      ST_WR_B: begin
        wr_we   = 1'b1;
        wr_addr = pwm_addr(chan_sel(PWM_B_BASE, ch));
        wr_data = high_rd;
        // The enable write happens once per run, not again after a loop wrap.
        if (first_reg) begin
          state_next = ST_WR_C;
        end else begin
          state_next = ST_HOLD;
          cnt_next   = hold_load;
        end
      end
      ST_WR_C: begin
        wr_we      = 1'b1;
        wr_addr    = pwm_addr(PWM_C_REG);
        wr_data    = PWM_C_VALUE;
        first_next = 1'b0;
        state_next = ST_HOLD;
        cnt_next   = hold_load;
      end
      ST_HOLD: begin
        if (cnt_reg == HOLD_W'(1)) begin
          if (!last_step) begin
            idx_next   = idx_inc[IDX_W-1:0];
            state_next = ST_WR_A;
          end else if (loop) begin
            idx_next   = '0;
            state_next = ST_WR_A;
          end else begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - HOLD_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Stop abandons the run from any state without signalling completion.
    if (stop_req) begin
      state_next = ST_IDLE;
      done_next  = 1'b0;
    end
  end

  // Outputs are held low for as long as reset is asserted.
  assign pwm_we_o   = rst & wr_we;
  assign pwm_addr_o = rst ? wr_addr : 32'd0;
  assign pwm_data_o = rst ? wr_data : 32'd0;
  assign busy_o     = rst & busy;
  assign done_o     = rst & done_reg;

`ifdef PWM_SEQ_IRQ_EN
  assign irq_o = rst & done_sticky;
`else
  logic unused_done_sticky;
  assign unused_done_sticky = done_sticky;
`endif

endmodule
